// File: rtl/miner_pkg.sv
// miner_pkg: shared types and constants for the mining datapath controller.
//
// Contents:
//   MSG_W, NONCE_W, DIGEST_W : default widths of the preprocessor message,
//                              the nonce and the SHA-256 digest / target.
//   digest_t                 : digest / target vector type.
//   state_t                  : nonce_scheduler FSM states. TMO exists only
//                              when MINER_TIMEOUT_EN is defined.
package miner_pkg;

  localparam int MSG_W    = 447;
  localparam int NONCE_W  = 32;
  localparam int DIGEST_W = 256;

  typedef logic [DIGEST_W-1:0] digest_t;

  typedef enum logic [3:0] {
    IDLE,
    PP_GO,
    PP_WAIT,
    H_GO,
    H_WAIT,
    CHECK,
    FOUND,
    EXHAUSTED
`ifdef MINER_TIMEOUT_EN
    , TMO
`endif
  } state_t;

endpackage

// File: rtl/nonce_counter.sv
// nonce_counter: holds the current nonce and the inclusive last nonce of a
// search range.
//
// Ports:
//   clk, n_rst : clock, asynchronous active-low reset
//   load       : capture first/last (start of a new search)
//   first      : first nonce of the range
//   last       : last nonce of the range (inclusive)
//   advance    : step to the next nonce; wraps from all-ones to zero
//   nonce      : current nonce
//   is_last    : current nonce equals the captured last nonce
module nonce_counter #(
  parameter int NONCE_W = 32
) (
  input  logic               clk,
  input  logic               n_rst,
  input  logic               load,
  input  logic [NONCE_W-1:0] first,
  input  logic [NONCE_W-1:0] last,
  input  logic               advance,
  output logic [NONCE_W-1:0] nonce,
  output logic               is_last
);

  logic [NONCE_W-1:0] nonce_q, nonce_d;
  logic [NONCE_W-1:0] last_q, last_d;

  // A first>last range simply wraps through zero, so plain modular
  // increment covers the whole space without any special casing.
  always_comb begin
    nonce_d = nonce_q;
    last_d  = last_q;
    if (load) begin
      nonce_d = first;
      last_d  = last;
    end else if (advance) begin
      nonce_d = nonce_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      nonce_q <= '0;
      last_q  <= '0;
    end else begin
      nonce_q <= nonce_d;
      last_q  <= last_d;
    end
  end

  assign nonce   = nonce_q;
  assign is_last = (nonce_q == last_q);

endmodule

// File: rtl/nonce_scheduler.sv
// nonce_scheduler: walks a nonce range, driving the preprocessor and the
// SHA-256 core for each nonce, and stops on the first digest strictly below
// the target or when the range is exhausted.
//
// Optional feature: define MINER_TIMEOUT_EN to add a watchdog (TMO_W bits)
// on the two wait states; on expiry the block parks in TMO with timeout=1.
//
// Ports:
//   clk, n_rst            : clock, asynchronous active-low reset
//   start, abort          : begin a search / force return to IDLE
//   header, nonce_first,
//   nonce_last, target    : search parameters, captured on start
//   pp_msg, pp_length     : preprocessor message {header, nonce} and length
//   pp_begin, pp_done     : preprocessor start pulse / done pulse
//   hash_start, hash_done,
//   hash_digest           : hash core start pulse / done pulse / digest
//   busy, found,
//   exhausted, timeout    : status levels
//   found_nonce           : winning nonce
module nonce_scheduler
  import miner_pkg::state_t;
#(
  parameter int MSG_W    = miner_pkg::MSG_W,
  parameter int NONCE_W  = miner_pkg::NONCE_W,
  parameter int DIGEST_W = miner_pkg::DIGEST_W,
  parameter int TMO_W    = 16
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     start,
  input  logic                     abort,
  input  logic [MSG_W-NONCE_W-1:0] header,
  input  logic [NONCE_W-1:0]       nonce_first,
  input  logic [NONCE_W-1:0]       nonce_last,
  input  logic [DIGEST_W-1:0]      target,
  output logic [MSG_W-1:0]         pp_msg,
  output logic [63:0]              pp_length,
  output logic                     pp_begin,
  input  logic                     pp_done,
  output logic                     hash_start,
  input  logic                     hash_done,
  input  logic [DIGEST_W-1:0]      hash_digest,
  output logic                     busy,
  output logic                     found,
  output logic                     exhausted,
  output logic [NONCE_W-1:0]       found_nonce,
  output logic                     timeout
);

  localparam int HDR_W = MSG_W - NONCE_W;

  state_t state_q, state_d;

  logic [HDR_W-1:0]    header_q, header_d;
  logic [DIGEST_W-1:0] target_q, target_d;
  logic [NONCE_W-1:0]  found_nonce_q, found_nonce_d;
  logic                less_q, less_d;

  logic               capture;
  logic               advance;
  logic               idle_like;
  logic [NONCE_W-1:0] nonce_cur;
  logic               is_last;
  logic               tmo_expire;

  nonce_counter #(
    .NONCE_W (NONCE_W)
  ) u_nonce_counter (
    .clk     (clk),
    .n_rst   (n_rst),
    .load    (capture),
    .first   (nonce_first),
    .last    (nonce_last),
    .advance (advance),
    .nonce   (nonce_cur),
    .is_last (is_last)
  );

`ifdef MINER_TIMEOUT_EN
  // Expiry fires in the cycle the counter is stepping onto all-ones, so the
  // block lands in TMO on the same edge the count would saturate.
  localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  assign tmo_expire = (tmo_cnt_q == TMO_LAST);

  always_comb begin
    tmo_cnt_d = tmo_cnt_q;
    if ((state_d == miner_pkg::PP_WAIT || state_d == miner_pkg::H_WAIT) &&
        (state_d != state_q)) begin
      tmo_cnt_d = '0;
    end else if (state_q == miner_pkg::PP_WAIT || state_q == miner_pkg::H_WAIT) begin
      tmo_cnt_d = tmo_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      tmo_cnt_q <= '0;
    end else begin
      tmo_cnt_q <= tmo_cnt_d;
    end
  end

  assign idle_like = (state_q == miner_pkg::IDLE) || (state_q == miner_pkg::FOUND) ||
                     (state_q == miner_pkg::EXHAUSTED) || (state_q == miner_pkg::TMO);
  assign timeout   = (state_q == miner_pkg::TMO);
`else
  assign tmo_expire = 1'b0;
  assign idle_like  = (state_q == miner_pkg::IDLE) || (state_q == miner_pkg::FOUND) ||
                      (state_q == miner_pkg::EXHAUSTED);
  assign timeout    = 1'b0;
`endif

  // Abort outranks every other event; done pulses only count in their own
  // wait state because each state looks at just its own input.
  always_comb begin
    state_d       = state_q;
    header_d      = header_q;
    target_d      = target_q;
    found_nonce_d = found_nonce_q;
    less_d        = less_q;
    capture       = 1'b0;
    advance       = 1'b0;

    if (abort) begin
      state_d = miner_pkg::IDLE;
    end else if (idle_like) begin
      if (start) begin
        capture  = 1'b1;
        header_d = header;
        target_d = target;
        state_d  = miner_pkg::PP_GO;
      end
    end else begin
      case (state_q)
        miner_pkg::PP_GO: state_d = miner_pkg::PP_WAIT;
        miner_pkg::PP_WAIT: begin
          if (pp_done) begin
            state_d = miner_pkg::H_GO;
          end else if (tmo_expire) begin
`ifdef MINER_TIMEOUT_EN
            state_d = miner_pkg::TMO;
`endif
          end
        end
        miner_pkg::H_GO: state_d = miner_pkg::H_WAIT;
        miner_pkg::H_WAIT: begin
          if (hash_done) begin
            less_d  = (hash_digest < target_q);
            state_d = miner_pkg::CHECK;
          end else if (tmo_expire) begin
`ifdef MINER_TIMEOUT_EN
            state_d = miner_pkg::TMO;
`endif
          end
        end
        miner_pkg::CHECK: begin
          if (less_q) begin
            found_nonce_d = nonce_cur;
            state_d       = miner_pkg::FOUND;
          end else if (is_last) begin
            state_d = miner_pkg::EXHAUSTED;
          end else begin
            advance = 1'b1;
            state_d = miner_pkg::PP_GO;
          end
        end
        default: state_d = miner_pkg::IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= miner_pkg::IDLE;
      header_q      <= '0;
      target_q      <= '0;
      found_nonce_q <= '0;
      less_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      header_q      <= header_d;
      target_q      <= target_d;
      found_nonce_q <= found_nonce_d;
      less_q        <= less_d;
    end
  end

  assign pp_msg      = {header_q, nonce_cur};
  assign pp_length   = 64'(MSG_W);
  assign pp_begin    = (state_q == miner_pkg::PP_GO);
  assign hash_start  = (state_q == miner_pkg::H_GO);
  assign busy        = !idle_like;
  assign found       = (state_q == miner_pkg::FOUND);
  assign exhausted   = (state_q == miner_pkg::EXHAUSTED);
  assign found_nonce = found_nonce_q;

endmodule
